// File: rtl/rf_dump_engine.sv
// Register-file dump engine: fetches two registers per FETCH and streams them one per beat, holding the payload under backpressure.
// Define RF_DUMP_CHECKSUM_EN to append one XOR-of-all-words beat (index 0, last=1) after the final register.
module rf_dump_engine #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rs_addr,
    output logic [ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int PAIR_W = ADDR_W - 1;
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_REGS / 2 - 1);

`ifdef RF_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, FETCH, SEND_A, SEND_B, DONE, CHK} state_t;
    logic [DATA_W-1:0] acc;
`else
    typedef enum logic [2:0] {IDLE, FETCH, SEND_A, SEND_B, DONE} state_t;
`endif

    state_t            state;
    logic [PAIR_W-1:0] pair;
    logic [DATA_W-1:0] buf_a;
    logic [DATA_W-1:0] buf_b;

    // Both words of a pair are captured on the same FETCH edge so each pair is a coherent snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pair      <= '0;
            rs_addr   <= '0;
            rt_addr   <= ADDR_W'(1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            buf_a     <= '0;
            buf_b     <= '0;
`ifdef RF_DUMP_CHECKSUM_EN
            acc       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rs_addr <= '0;
                        rt_addr <= ADDR_W'(1);
                        pair    <= '0;
                        busy    <= 1'b1;
                        state   <= FETCH;
`ifdef RF_DUMP_CHECKSUM_EN
                        acc     <= '0;
`endif
                    end
                end
                FETCH: begin
                    buf_a     <= rs_data;
                    buf_b     <= rt_data;
                    out_valid <= 1'b1;
                    out_data  <= rs_data;
                    out_index <= {pair, 1'b0};
                    out_last  <= 1'b0;
                    state     <= SEND_A;
                end
                SEND_A: begin
                    if (out_ready) begin
`ifdef RF_DUMP_CHECKSUM_EN
                        acc      <= acc ^ buf_a;
                        out_last <= 1'b0;
`else
                        out_last <= (pair == LAST_PAIR);
`endif
                        out_data  <= buf_b;
                        out_index <= {pair, 1'b1};
                        state     <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (out_ready) begin
`ifdef RF_DUMP_CHECKSUM_EN
                        acc <= acc ^ buf_b;
`endif
                        if (pair == LAST_PAIR) begin
`ifdef RF_DUMP_CHECKSUM_EN
                            out_data  <= acc ^ buf_b;
                            out_index <= '0;
                            out_last  <= 1'b1;
                            state     <= CHK;
`else
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
`endif
                        end else begin
                            pair      <= pair + PAIR_W'(1);
                            rs_addr   <= rs_addr + ADDR_W'(2);
                            rt_addr   <= rt_addr + ADDR_W'(2);
                            out_valid <= 1'b0;
                            state     <= FETCH;
                        end
                    end
                end
`ifdef RF_DUMP_CHECKSUM_EN
                CHK: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    // start is deliberately not sampled here; it is accepted from the next IDLE cycle.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_dump_engine.sv
// Scoreboard bench for rf_dump_engine: a behavioural register file feeds the DUT, expected beats are queued per start.
module tb_rf_dump_engine;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] rs_addr, rt_addr, out_index;
    logic [DW-1:0] rs_data, rt_data, out_data;
    logic          out_valid, out_last, busy, done;

    logic [DW-1:0] rf [NR];

    assign rs_data = (rs_addr == '0) ? '0 : rf[rs_addr];
    assign rt_data = (rt_addr == '0) ? '0 : rf[rt_addr];

    rf_dump_engine #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t exp_b;
    beat_t prev;
    logic  prev_stall = 1'b0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int ready_mode = 0;
    int rcnt = 0;
    int t0 = 0;

`ifdef RF_DUMP_CHECKSUM_EN
    localparam int DONE_LAT = 3 * NR / 2 + 1;
`else
    localparam int DONE_LAT = 3 * NR / 2;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
                rcnt++;
            end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: handshake checks, payload stability under stall, address invariants.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {out_valid, out_data, out_index, out_last}, {1'b1, prev});
            if (busy) begin
                check("rs_even", 64'(rs_addr[0]), 64'd0);
                check("rt_pair", 64'(rt_addr), 64'(AW'(rs_addr + AW'(1))));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got idx %0d data %0h, want no beat", out_index, out_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("beat", 64'({out_data, out_index, out_last}), 64'(exp_b));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev = {out_data, out_index, out_last};
        end
    end

    // Reference model: one dump is every register in index order, reg 0 reading as zero.
    task automatic push_dump();
        logic [DW-1:0] x = '0;
        logic [DW-1:0] v;
        for (int i = 0; i < NR; i++) begin
            v = (i == 0) ? '0 : rf[i];
            x ^= v;
`ifdef RF_DUMP_CHECKSUM_EN
            exp_q.push_back({v, AW'(i), 1'b0});
`else
            exp_q.push_back({v, AW'(i), (i == NR - 1)});
`endif
        end
`ifdef RF_DUMP_CHECKSUM_EN
        exp_q.push_back({x, AW'(0), 1'b1});
`endif
    endtask

    task automatic do_start(input bit expect_dump);
        if (expect_dump) push_dump();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #2;
            if (done_cnt != d0) return;
        end
        total++;
        bad++;
        $display("FAIL %s_timeout: got no done, want done within %0d cycles", name, budget);
    endtask

    task automatic wait_index(input string name, input int idx, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #2;
            if (out_valid && out_index == AW'(idx)) return;
        end
        total++;
        bad++;
        $display("FAIL %s_timeout: got no index %0d, want it within %0d cycles", name, idx, budget);
    endtask

    task automatic settle(input string name, input int d0);
        repeat (6) @(negedge clk);
        #2;
        check({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < NR; i++) rf[i] = DW'(NR - 1 - i);

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_rs_addr", 64'(rs_addr), 64'd0);
        check("rst_rt_addr", 64'(rt_addr), 64'd1);
        check("rst_out", 64'({out_valid, out_data, out_index, out_last}), 64'd0);
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_stays", 64'({busy, out_valid, done}), 64'd0);
        end

        // Full dump, ready tied high
        ready_mode = 0;
        d0 = done_cnt;
        do_start(1'b1);
        for (int k = 0; k < 5 && !out_valid; k++) @(negedge clk);
        check("first_valid_cycle", 64'(cyc - t0), 64'd1);
        wait_done("full", 200);
        check("done_latency", 64'(done_cyc - t0), 64'(DONE_LAT));
        settle("full", d0);

        // Backpressure 1,0,0,1
        ready_mode = 1;
        rcnt = 0;
        d0 = done_cnt;
        do_start(1'b1);
        wait_done("bp", 400);
        settle("bp", d0);

        // Start while busy, then back-to-back with start held through DONE
        ready_mode = 2;
        for (int i = 0; i < NR; i++) rf[i] = $urandom;
        d0 = done_cnt;
        do_start(1'b1);
        wait_index("busy_start", 5, 100);
        do_start(1'b0);
        wait_done("busy", 400);
        check("busy_one_done", 64'(done_cnt - d0), 64'd1);
        check("busy_queue", 64'(exp_q.size()), 64'd0);
        push_dump();
        start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        d0 = done_cnt;
        wait_done("b2b", 400);
        settle("b2b", d0);

        // Reset mid-dump
        ready_mode = 0;
        do_start(1'b1);
        wait_index("rst_mid", 12, 100);
        rst = 1'b0;
        #1;
        check("rst_mid_valid", 64'({out_valid, busy, out_last}), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        d0 = done_cnt;
        do_start(1'b1);
        for (int k = 0; k < 5 && !out_valid; k++) @(negedge clk);
        check("rst_restart_idx", 64'({out_valid, out_index}), 64'({1'b1, AW'(0)}));
        wait_done("rst_restart", 200);
        settle("rst_restart", d0);

        // Random contents under random backpressure
        ready_mode = 2;
        for (int i = 0; i < NR; i++) rf[i] = $urandom;
        d0 = done_cnt;
        do_start(1'b1);
        wait_done("rand", 400);
        settle("rand", d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_dump_engine.md
Name: rf_dump_engine

Overview:
- Read-side companion to the 32x32 `register_file`. On a start pulse it walks every register through the `rs` and `rt` read ports, two registers per fetch.
- It streams the contents out one word per beat on a valid/ready interface.
- It is used for debug snapshot and bench scoreboarding of architectural state.
- It never drives the write port.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, registers dumped. Must be even and at most 2**ADDR_W.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request to begin a dump. Ignored while busy=1.
- rs_addr  out  ADDR_W  to register_file rs_addr. Always even register index.
- rt_addr  out  ADDR_W  to register_file rt_addr. Always rs_addr+1.
- rs_data  in  DATA_W  from register_file. Combinational read of rs_addr.
- rt_data  in  DATA_W  from register_file. Combinational read of rt_addr.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat when valid&ready at a clk edge.
- out_data  out  DATA_W  register contents.
- out_index  out  ADDR_W  register number of out_data.
- out_last  out  1  final beat of the dump.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst=0, asynchronous) applies immediately:
  - state=IDLE, pair=0;
  - rs_addr=0, rt_addr=1;
  - out_valid=0, out_data=0, out_index=0, out_last=0;
  - busy=0, done=0;
  - both capture buffers cleared.
- Reset mid-dump aborts with no further beats. The next start restarts from register 0.
- All outputs are registered or decoded only from state and registers. There is no combinational path from out_ready to out_valid.
- FSM states: IDLE, FETCH, SEND_A, SEND_B, DONE (plus CHK under the macro).
  - IDLE: busy=0. start=1 → load rs_addr=0, rt_addr=1, pair=0 → FETCH.
  - FETCH: addresses are stable. At the edge, capture buf_a<=rs_data and buf_b<=rt_data → SEND_A. busy=1.
  - SEND_A: out_valid=1, out_data=buf_a, out_index=2*pair. It holds until out_ready=1, then → SEND_B.
  - SEND_B: out_valid=1, out_data=buf_b, out_index=2*pair+1. On out_ready=1:
    - if pair==NUM_REGS/2-1 → DONE;
    - else pair++, rs_addr+=2, rt_addr+=2 → FETCH.
  - DONE: done=1 for exactly one cycle, out_valid=0, busy=0 → IDLE.
- out_last=1 only in SEND_B of the final pair.
- Beat payload (out_data, out_index, out_last) must not change while out_valid=1 and out_ready=0.
- Latency with out_ready tied high:
  - start sampled at edge E0;
  - first out_valid high after E1;
  - 3 cycles per pair;
  - done high in the cycle after E(3*NUM_REGS/2), i.e. after E48 for the default.
- Back-to-back: start asserted during DONE is ignored. start in the following IDLE cycle is accepted.
- rs_addr and rt_addr change only on FETCH entry and reset. Buffered data is therefore a coherent snapshot per pair only.
- Writes to the register file during a dump are visible if they land before that pair's FETCH edge. No locking is provided.
- Arithmetic: pair counter width ADDR_W-1. Address increments do not wrap within a dump.

Optional Feature:
- Macro: RF_DUMP_CHECKSUM_EN.
- Defined:
  - a DATA_W XOR accumulator clears on start and folds each accepted beat's out_data;
  - after the final SEND_B handshake, state CHK presents one extra beat: out_data = XOR of all NUM_REGS words, out_index=0, out_last=1;
  - in this mode out_last is not asserted in SEND_B;
  - CHK → DONE on out_ready;
  - total beats = NUM_REGS+1.
- Undefined: no accumulator, no CHK state, exactly NUM_REGS beats, behaviour as above.

Test Plan:
- Reset values: hold rst=0 for 3 cycles.
  - Expect all outputs at reset values: rs_addr=0, rt_addr=1, out_valid=0, busy=0.
  - Release reset with no start; the block stays IDLE for 10 cycles.
- Full dump, out_ready=1: bench writes reg i = 31-i through the rd port (reg 0 reads 0), then pulses start.
  - Expect 32 beats in index order 0..31 with out_data = {0, 30, 29, …, 0}.
  - out_last only on index 31.
  - done pulse 48 cycles after the start edge.
- Backpressure: out_ready toggles 1,0,0,1 repeating.
  - Payload stays stable while stalled.
  - No beat is dropped or duplicated; the 32 beats match the full-dump scenario.
  - rs_addr is never odd.
- Start while busy: pulse start at beat 5 of a dump.
  - The dump completes unchanged with exactly one done.
  - A start one cycle after done launches a second identical dump.
- Reset mid-operation: assert rst at index 12 with out_ready=1.
  - out_valid=0 immediately, asynchronously.
  - After release, a new start yields index 0 first.
- Checksum (RF_DUMP_CHECKSUM_EN): registers preloaded as in the full-dump scenario.
  - The 33rd beat carries out_data = XOR of 0 and 30..0 = 0x0000001F, with out_last=1 and out_index=0.
  - Beat 32 (index 31) has out_last=0.
